// File: rtl/playback_rate_gen.sv
// Sample-rate enable generator for the audio player/recorder: divides CLK50 into
// single-cycle ticks and supplies address step and interpolation phase per tick.
module playback_rate_gen #(
  parameter int BASE_DIV = 4,
  parameter int RATIO_W  = 3,
  parameter int STEP_W   = 4
) (
  input  logic               CLK50,
  input  logic               RST,
  input  logic [1:0]         i_mode,
  input  logic [RATIO_W-1:0] i_ratio,
  input  logic               i_interp,
  input  logic               i_pause,
  output logic               o_tick,
  output logic               o_advance,
  output logic [STEP_W-1:0]  o_step,
  output logic [RATIO_W-1:0] o_phase,
  output logic [RATIO_W:0]   o_den
);

  localparam int DIV_W = (BASE_DIV <= 2) ? 1 : $clog2(BASE_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(BASE_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
  localparam logic [RATIO_W:0]   DEN_ONE   = (RATIO_W + 1)'(1);
  localparam logic [1:0]         MODE_FAST = 2'b10;
  localparam logic [1:0]         MODE_SLOW = 2'b11;

  logic [DIV_W-1:0]   div_cnt;
  logic [RATIO_W-1:0] phase_cnt;
  logic [RATIO_W-1:0] ratio_q;
  logic [1:0]         mode_q;

  logic               tick_due;
  logic               slow;
  logic               phase_end;
  logic               group_end;
  logic [RATIO_W:0]   ratio_p1;
  logic [STEP_W-1:0]  step_fast;

  // ratio+1 is formed one bit wider so the maximum ratio does not wrap.
  assign ratio_p1  = {1'b0, ratio_q} + DEN_ONE;
  assign step_fast = STEP_W'(ratio_p1);
  assign tick_due  = (div_cnt == DIV_LAST);
  assign slow      = (mode_q == MODE_SLOW);
  // >= keeps the group closing even if a ratio reload during pause left phase_cnt above it.
  assign phase_end = (phase_cnt >= ratio_q);
  assign group_end = !slow || phase_end;

  always_ff @(posedge CLK50) begin
    if (RST) begin
      div_cnt   <= '0;
      phase_cnt <= '0;
      mode_q    <= 2'b01;
      ratio_q   <= '0;
      o_tick    <= 1'b0;
      o_advance <= 1'b0;
      o_step    <= '0;
      o_phase   <= '0;
      o_den     <= DEN_ONE;
    end else if (i_pause) begin
      div_cnt   <= '0;
      mode_q    <= i_mode;
      ratio_q   <= i_ratio;
      o_tick    <= 1'b0;
      o_advance <= 1'b0;
      o_step    <= '0;
      o_phase   <= '0;
    end else begin
      o_tick    <= tick_due;
      o_advance <= 1'b0;
      o_step    <= '0;
      o_phase   <= '0;
      div_cnt   <= tick_due ? '0 : div_cnt + DIV_W'(1);
      if (tick_due) begin
        // Settings loaded here are first used by the following tick.
        if (group_end) begin
          mode_q  <= i_mode;
          ratio_q <= i_ratio;
        end
        if (slow) begin
          o_phase <= i_interp ? phase_cnt : '0;
          o_den   <= ratio_p1;
          if (phase_end) begin
            o_advance <= 1'b1;
            o_step    <= STEP_ONE;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + RATIO_W'(1);
          end
        end else begin
          o_advance <= 1'b1;
          o_step    <= (mode_q == MODE_FAST) ? step_fast : STEP_ONE;
          o_den     <= DEN_ONE;
          phase_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_playback_rate_gen.sv
// Directed bench for playback_rate_gen: expected ticks are queued as settings are
// driven and popped as the DUT emits them, with tick spacing checked every cycle.
module tb_playback_rate_gen;

  localparam int BASE_DIV = 4;
  localparam int RATIO_W  = 3;
  localparam int STEP_W   = 4;

  logic               clk50 = 1'b0;
  logic               rst;
  logic [1:0]         i_mode;
  logic [RATIO_W-1:0] i_ratio;
  logic               i_interp;
  logic               i_pause;
  logic               o_tick;
  logic               o_advance;
  logic [STEP_W-1:0]  o_step;
  logic [RATIO_W-1:0] o_phase;
  logic [RATIO_W:0]   o_den;

  playback_rate_gen #(.BASE_DIV(BASE_DIV), .RATIO_W(RATIO_W), .STEP_W(STEP_W)) dut (
    .CLK50(clk50), .RST(rst), .i_mode(i_mode), .i_ratio(i_ratio), .i_interp(i_interp),
    .i_pause(i_pause), .o_tick(o_tick), .o_advance(o_advance), .o_step(o_step),
    .o_phase(o_phase), .o_den(o_den)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic adv;
    int   step;
    int   phase;
    int   den;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   since_tick  = 0;
  int   tick_no     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic adv, input int step, input int phase, input int den);
    exp_t e;
    e.adv = adv; e.step = step; e.phase = phase; e.den = den;
    exp_q.push_back(e);
  endtask

  // One clock: sample after the edge, check tick timing and contents.
  task automatic cyc();
    logic exp_tick;
    exp_t e;
    @(posedge clk50);
    #1;
    since_tick++;
    exp_tick = (exp_q.size() > 0) && (since_tick == BASE_DIV);
    chk($sformatf("tick@%0d", since_tick), {31'b0, o_tick}, {31'b0, exp_tick});
    if (o_tick === 1'b1 || exp_tick) begin
      since_tick = 0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tick_no++;
        chk($sformatf("adv#%0d", tick_no), {31'b0, o_advance}, {31'b0, e.adv});
        chk($sformatf("step#%0d", tick_no), {28'b0, o_step}, e.step);
        chk($sformatf("phase#%0d", tick_no), {29'b0, o_phase}, e.phase);
        chk($sformatf("den#%0d", tick_no), {28'b0, o_den}, e.den);
        $display("tick %0d: adv=%0d step=%0d phase=%0d den=%0d", tick_no,
                 o_advance, o_step, o_phase, o_den);
      end
    end else begin
      chk("idle", {24'b0, o_advance, o_step, o_phase}, 32'd0);
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      cyc();
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tick"},  {31'b0, o_tick},    32'd0);
    chk({tag, "_adv"},   {31'b0, o_advance}, 32'd0);
    chk({tag, "_step"},  {28'b0, o_step},    32'd0);
    chk({tag, "_phase"}, {29'b0, o_phase},   32'd0);
    chk({tag, "_den"},   {28'b0, o_den},     32'd1);
  endtask

  initial begin
    rst = 1'b1; i_mode = 2'b01; i_ratio = '0; i_interp = 1'b0; i_pause = 1'b0;

    // Reset, then normal mode: first tick 4 cycles after release.
    cyc();
    chk_reset("rst");
    since_tick = 0;
    rst = 1'b0;
    repeat (3) push(1, 1, 0, 1);
    drain(100);

    // Fast x4: one more normal tick while the new setting latches.
    i_mode = 2'b10; i_ratio = 3'd3;
    push(1, 1, 0, 1);
    repeat (3) push(1, 4, 0, 1);
    drain(100);
    i_ratio = 3'd7;
    push(1, 4, 0, 1);
    repeat (2) push(1, 8, 0, 1);
    drain(100);

    // Slow ratio 2 with interpolation, then zero-order hold.
    i_mode = 2'b11; i_ratio = 3'd2; i_interp = 1'b1;
    push(1, 8, 0, 1);
    repeat (2) begin
      push(0, 0, 0, 3); push(0, 0, 1, 3); push(1, 1, 2, 3);
    end
    drain(100);
    i_interp = 1'b0;
    repeat (2) begin
      push(0, 0, 0, 3); push(0, 0, 0, 3); push(1, 1, 0, 3);
    end
    drain(100);

    // Ratio 3 requested: current ratio-2 group completes first.
    i_ratio = 3'd3; i_interp = 1'b1;
    push(0, 0, 0, 3); push(0, 0, 1, 3); push(1, 1, 2, 3);
    push(0, 0, 0, 4); push(0, 0, 1, 4);
    drain(100);
    i_ratio = 3'd1;
    push(0, 0, 2, 4); push(1, 1, 3, 4);
    repeat (2) begin
      push(0, 0, 0, 2); push(1, 1, 1, 2);
    end
    push(0, 0, 0, 2);
    drain(100);
    i_mode = 2'b01; i_ratio = 3'd0;
    push(1, 1, 1, 2);
    repeat (2) push(1, 1, 0, 1);
    drain(100);

    // Pause for 10 cycles at slow phase 1 of ratio 3.
    i_mode = 2'b11; i_ratio = 3'd3;
    push(1, 1, 0, 1); push(0, 0, 0, 4); push(0, 0, 1, 4);
    drain(100);
    i_pause = 1'b1;
    repeat (10) cyc();
    i_pause = 1'b0;
    since_tick = 0;
    push(0, 0, 2, 4);
    drain(100);

    // Reset together with pause mid-group.
    rst = 1'b1; i_pause = 1'b1;
    cyc();
    chk_reset("rst2");
    rst = 1'b0; i_pause = 1'b0; i_mode = 2'b01; i_ratio = 3'd0; i_interp = 1'b0;
    since_tick = 0;
    repeat (3) push(1, 1, 0, 1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
